// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/load-store request buses and the shared memory port.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_rvalid;
   logic [DATA_W-1:0] ls_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport master (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_wdata, mem_we, busy
   );
   modport slave (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_addr, mem_wdata, mem_we, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (LS),
// LS first with an IF starvation guard, and absorbs the fixed memory read latency.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 3,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR} state_t;

   state_t            state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d, ls_streak_q, ls_streak_d;
   logic              owner_ls_q, owner_ls_d;
   logic              if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
   logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
   logic              pick_ls;

   // LS wins ties unless IF has already sat through STARVE_MAX LS grants
   assign pick_ls = bus.ls_req && !(bus.if_req && ls_streak_q == 4'(STARVE_MAX));

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      ls_streak_d = ls_streak_q;
      owner_ls_d  = owner_ls_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_gnt_d    = 1'b0;
      ls_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      case (state_q)
         IDLE: if (bus.if_req || bus.ls_req) begin
            owner_ls_d  = pick_ls;
            if_gnt_d    = !pick_ls;
            ls_gnt_d    = pick_ls;
            ls_streak_d = (pick_ls && bus.if_req) ? ls_streak_q + 4'd1 : 4'd0;
            mem_addr_d  = pick_ls ? bus.ls_addr : bus.if_addr;
            mem_wdata_d = (pick_ls && bus.ls_we) ? bus.ls_wdata : mem_wdata_q;
            state_d     = (pick_ls && bus.ls_we) ? WR : RD_WAIT;
            wait_cnt_d  = 4'(RD_LAT - 1);
         end
         RD_WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd0) begin
               state_d     = IDLE;
               if_rvalid_d = !owner_ls_q;
               ls_rvalid_d = owner_ls_q;
               if_rdata_d  = owner_ls_q ? if_rdata_q : bus.mem_rdata;
               ls_rdata_d  = owner_ls_q ? bus.mem_rdata : ls_rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         ls_streak_q <= '0;
         owner_ls_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         ls_streak_q <= ls_streak_d;
         owner_ls_q  <= owner_ls_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         if_gnt_q    <= if_gnt_d;
         ls_gnt_q    <= ls_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.ls_gnt    = ls_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.ls_rvalid = ls_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = state_q == WR;
   assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed traffic against a transaction-level
// model; expected grants, writes and read returns are queued and checked by a monitor.
module tb_mem_port_arbiter;
   localparam int RD_LAT     = 3;
   localparam int STARVE_MAX = 4;

   typedef struct packed {int cyc; int n; logic [63:0] v;} ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   ev_t         q[5][$];
   int          streak = 0;
   int          idle_from = 0;
   int          busy_until = -1;
   bit          rst_prev = 1'b1;
   logic [31:0] exp_if_rd = '0;
   logic [31:0] exp_ls_rd = '0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory word depends on the address and the cycle, so capture timing shows in the data
   function automatic logic [31:0] mem_fn(input logic [31:0] a, input int c);
      return {a[15:0] ^ a[31:16] ^ 16'h5a3c, c[15:0]};
   endfunction

   assign bus.mem_rdata = mem_fn(bus.mem_addr, cyc);

   // Reference: one transaction at a time, LS first unless IF has waited STARVE_MAX grants
   always @(negedge clk) begin
      bit          ls_wins, st;
      logic [31:0] a;
      ev_t         e;
      if (reset) begin
         for (int k = 0; k < 5; k++)
            while (q[k].size() > 0 && q[k][$].cyc > cyc) void'(q[k].pop_back());
         streak = 0;
         idle_from = cyc + 1;
      end else if (cyc >= idle_from && (bus.if_req || bus.ls_req)) begin
         ls_wins = bus.ls_req && !(bus.if_req && streak == STARVE_MAX);
         streak  = (ls_wins && bus.if_req) ? ((streak < STARVE_MAX) ? streak + 1 : streak) : 0;
         st      = ls_wins && bus.ls_we;
         a       = ls_wins ? bus.ls_addr : bus.if_addr;
         e.cyc = cyc + 1;
         e.n   = st ? 1 : RD_LAT;
         e.v   = {a, 32'h0};
         q[ls_wins ? 1 : 0].push_back(e);
         if (st) begin
            e.n = 0;
            e.v = {a, bus.ls_wdata};
            q[4].push_back(e);
            idle_from = cyc + 2;
         end else begin
            e.cyc = cyc + RD_LAT + 1;
            e.n   = 0;
            e.v   = {32'h0, mem_fn(a, cyc + RD_LAT)};
            q[ls_wins ? 3 : 2].push_back(e);
            idle_from = cyc + RD_LAT + 1;
         end
      end
   end

   task automatic take(input int k, input logic fired, input logic [63:0] got, input string nm,
                       output bit hit, output ev_t e);
      hit = 1'b0;
      e   = '0;
      if (fired) begin
         compared++;
         if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
            mismatched++;
            $display("FAIL %s unexpected at cycle %0d: got %h, required no event", nm, cyc, got);
         end else begin
            e   = q[k].pop_front();
            hit = 1'b1;
            if (got !== e.v) begin
               mismatched++;
               $display("FAIL %s value at cycle %0d: got %h, required %h", nm, cyc, got, e.v);
            end
         end
      end
      while (q[k].size() > 0 && q[k][0].cyc <= cyc) begin
         compared++;
         mismatched++;
         $display("FAIL %s missing at cycle %0d: got none, required %h", nm, q[k][0].cyc, q[k][0].v);
         void'(q[k].pop_front());
      end
   endtask

   always @(negedge clk) begin
      bit  hit;
      ev_t e;
      if (rst_prev) begin
         busy_until = -1;
         exp_if_rd  = '0;
         exp_ls_rd  = '0;
         compared++;
         if ({bus.busy, bus.mem_we, bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
              bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ls_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_state cycle %0d: busy=%b we=%b gnt=%b%b rv=%b%b addr=%h wdata=%h if_rd=%h ls_rd=%h, required all 0",
                     cyc, bus.busy, bus.mem_we, bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
                     bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.ls_rdata);
         end
      end
      rst_prev = reset;
      take(0, bus.if_gnt, {bus.mem_addr, 32'h0}, "if_gnt", hit, e);
      if (hit) busy_until = cyc + e.n - 1;
      take(1, bus.ls_gnt, {bus.mem_addr, 32'h0}, "ls_gnt", hit, e);
      if (hit) busy_until = cyc + e.n - 1;
      take(2, bus.if_rvalid, {32'h0, bus.if_rdata}, "if_rvalid", hit, e);
      if (hit) exp_if_rd = e.v[31:0];
      take(3, bus.ls_rvalid, {32'h0, bus.ls_rdata}, "ls_rvalid", hit, e);
      if (hit) exp_ls_rd = e.v[31:0];
      take(4, bus.mem_we, {bus.mem_addr, bus.mem_wdata}, "mem_write", hit, e);
      compared += 3;
      if (bus.busy !== (cyc <= busy_until)) begin
         mismatched++;
         $display("FAIL busy at cycle %0d: got %b, required %b", cyc, bus.busy, cyc <= busy_until);
      end
      if (bus.if_rdata !== exp_if_rd) begin
         mismatched++;
         $display("FAIL if_rdata_hold at cycle %0d: got %h, required %h", cyc, bus.if_rdata, exp_if_rd);
      end
      if (bus.ls_rdata !== exp_ls_rd) begin
         mismatched++;
         $display("FAIL ls_rdata_hold at cycle %0d: got %h, required %h", cyc, bus.ls_rdata, exp_ls_rd);
      end
   end

   task automatic if_issue(input logic [31:0] a);
      bit got = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk);
         #1 got = bus.if_gnt;
      end
      bus.if_req = 1'b0;
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL if_gnt_timeout addr %h: got no grant in 300 cycles, required a grant", a);
      end
   endtask

   task automatic ls_issue(input logic we, input logic [31:0] a, input logic [31:0] d);
      bit got = 1'b0;
      bus.ls_req   = 1'b1;
      bus.ls_we    = we;
      bus.ls_addr  = a;
      bus.ls_wdata = d;
      for (int i = 0; i < 300 && !got; i++) begin
         @(posedge clk);
         #1 got = bus.ls_gnt;
      end
      bus.ls_req = 1'b0;
      if (!got) begin
         compared++;
         mismatched++;
         $display("FAIL ls_gnt_timeout addr %h: got no grant in 300 cycles, required a grant", a);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = '0;
      bus.ls_wdata = '0;
      idle(3);
      reset = 1'b0;
      if_issue(32'h0000_0040);
      idle(RD_LAT + 4);
      ls_issue(1'b1, 32'h0000_0100, 32'hdead_beef);
      idle(RD_LAT + 4);
      fork
         if_issue(32'h0000_0044);
         ls_issue(1'b0, 32'h0000_0200, 32'h0);
      join
      idle(RD_LAT + 4);
      fork
         if_issue(32'h0000_0080);
         for (int i = 0; i < 6; i++) ls_issue(1'b1, 32'h0000_0400 + 32'(i * 4), $urandom);
      join
      idle(RD_LAT + 4);
      if_issue(32'h0000_0300);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(RD_LAT + 4);
      if_issue(32'h0000_0000);
      if_issue(32'h0000_0004);
      idle(RD_LAT + 4);
      fork
         for (int i = 0; i < 150; i++) begin
            idle($urandom_range(0, 3));
            if_issue($urandom & 32'hffff_fffc);
         end
         for (int i = 0; i < 150; i++) begin
            idle($urandom_range(0, 2));
            ls_issue(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, $urandom);
         end
         for (int i = 0; i < 3; i++) begin
            idle($urandom_range(80, 250));
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end
      join
      idle(20);
      compared++;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d outstanding expected events, required 0",
                  q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test by 2 ms, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
